// File: rtl/bcd_conv_scheduler.sv
// Shares one combinational binary-to-BCD converter across the hours, minutes and
// seconds fields, committing all three display fields together on one edge.
module bcd_conv_scheduler (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_refresh,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  output logic [6:0] o_conv_binary,
  input  logic [3:0] i_conv_bcd_msb,
  input  logic [3:0] i_conv_bcd_lsb,
  output logic [7:0] o_hours_bcd,
  output logic [7:0] o_minutes_bcd,
  output logic [7:0] o_seconds_bcd,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_H = 2'd1,
    ST_CONV_M = 2'd2,
    ST_CONV_S = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_pending;
  logic [4:0] r_snap_h;
  logic [5:0] r_snap_m;
  logic [5:0] r_snap_s;
  logic [7:0] r_shadow_h;
  logic [7:0] r_shadow_m;
  logic [6:0] r_conv_binary;
  logic [7:0] r_hours_bcd;
  logic [7:0] r_minutes_bcd;
  logic [7:0] r_seconds_bcd;
  logic       r_busy;
  logic       r_done;
  logic [7:0] w_conv_bcd;

  assign w_conv_bcd = {i_conv_bcd_msb, i_conv_bcd_lsb};

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking would let later statements see the updated state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_pending     <= 1'b0;
      r_snap_h      <= '0;
      r_snap_m      <= '0;
      r_snap_s      <= '0;
      r_shadow_h    <= '0;
      r_shadow_m    <= '0;
      r_conv_binary <= '0;
      r_hours_bcd   <= '0;
      r_minutes_bcd <= '0;
      r_seconds_bcd <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i_en) begin
        // Abort: committed outputs are left untouched so the display keeps its last value.
        r_state       <= ST_IDLE;
        r_pending     <= 1'b0;
        r_shadow_h    <= '0;
        r_shadow_m    <= '0;
        r_conv_binary <= '0;
        r_busy        <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_refresh || r_pending) begin
              r_snap_h      <= i_hours;
              r_snap_m      <= i_minutes;
              r_snap_s      <= i_seconds;
              r_conv_binary <= {2'b00, i_hours};
              r_pending     <= 1'b0;
              r_busy        <= 1'b1;
              r_state       <= ST_CONV_H;
            end
          end
          ST_CONV_H: begin
            r_shadow_h    <= w_conv_bcd;
            r_conv_binary <= {1'b0, r_snap_m};
            if (i_refresh) r_pending <= 1'b1;
            r_state       <= ST_CONV_M;
          end
          ST_CONV_M: begin
            r_shadow_m    <= w_conv_bcd;
            r_conv_binary <= {1'b0, r_snap_s};
            if (i_refresh) r_pending <= 1'b1;
            r_state       <= ST_CONV_S;
          end
          ST_CONV_S: begin
            // Seconds come straight from the converter so all three fields land together.
            r_hours_bcd   <= r_shadow_h;
            r_minutes_bcd <= r_shadow_m;
            r_seconds_bcd <= w_conv_bcd;
            r_done        <= 1'b1;
            r_pending     <= 1'b0;
            if (r_pending || i_refresh) begin
              r_snap_h      <= i_hours;
              r_snap_m      <= i_minutes;
              r_snap_s      <= i_seconds;
              r_conv_binary <= {2'b00, i_hours};
              r_busy        <= 1'b1;
              r_state       <= ST_CONV_H;
            end else begin
              r_conv_binary <= '0;
              r_busy        <= 1'b0;
              r_state       <= ST_IDLE;
            end
          end
          default: begin
            r_conv_binary <= '0;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_conv_binary = r_conv_binary;
  assign o_hours_bcd   = r_hours_bcd;
  assign o_minutes_bcd = r_minutes_bcd;
  assign o_seconds_bcd = r_seconds_bcd;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Self-checking bench for bcd_conv_scheduler: models the external converter and
// scoreboards each commit against the field values captured at its request.
module tb_bcd_conv_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       refresh;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [6:0] conv_binary;
  logic [3:0] conv_msb;
  logic [3:0] conv_lsb;
  logic [7:0] hours_bcd;
  logic [7:0] minutes_bcd;
  logic [7:0] seconds_bcd;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] sb_q[$];
  logic        prev_done = 1'b0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared combinational converter.
  assign conv_msb = 4'(conv_binary / 7'd10);
  assign conv_lsb = 4'(conv_binary % 7'd10);

  bcd_conv_scheduler dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_en           (en),
    .i_refresh      (refresh),
    .i_hours        (hours),
    .i_minutes      (minutes),
    .i_seconds      (seconds),
    .o_conv_binary  (conv_binary),
    .i_conv_bcd_msb (conv_msb),
    .i_conv_bcd_lsb (conv_lsb),
    .o_hours_bcd    (hours_bcd),
    .o_minutes_bcd  (minutes_bcd),
    .o_seconds_bcd  (seconds_bcd),
    .o_busy         (busy),
    .o_done         (done)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] exp_bcd(input int h, input int m, input int s);
    return {to_bcd(h), to_bcd(m), to_bcd(s)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_vec++;
      if (prev_done === 1'b1) begin
        n_err++;
        $display("FAIL done_consecutive: done high two cycles in a row at %0t", $time);
      end
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got %h/%h/%h with no request outstanding",
                 hours_bcd, minutes_bcd, seconds_bcd);
      end else begin
        logic [23:0] exp;
        exp = sb_q.pop_front();
        if ({hours_bcd, minutes_bcd, seconds_bcd} !== exp) begin
          n_err++;
          $display("FAIL commit: got %h/%h/%h expected %h/%h/%h", hours_bcd, minutes_bcd,
                   seconds_bcd, exp[23:16], exp[15:8], exp[7:0]);
        end
      end
    end
    if (rst_n === 1'b1 && conv_binary > 7'd63) begin
      n_err++;
      $display("FAIL conv_range: operand %0d exceeds 63", conv_binary);
    end
    prev_done = done;
  end

  // Issue one request and wait (bounded) for its commit, then check the outputs.
  task automatic run_update(input string name, input int h, input int m, input int s);
    bit seen = 0;
    hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
    refresh = 1'b1;
    sb_q.push_back(exp_bcd(h, m, s));
    step();
    refresh = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: no done within 10 cycles", name);
    end else if ({hours_bcd, minutes_bcd, seconds_bcd} !== exp_bcd(h, m, s)) begin
      n_err++;
      $display("FAIL %s: got %h/%h/%h expected %h/%h/%h", name, hours_bcd, minutes_bcd,
               seconds_bcd, to_bcd(h), to_bcd(m), to_bcd(s));
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      refresh = 1'($urandom); hours = 5'($urandom); minutes = 6'($urandom); seconds = 6'($urandom);
      step();
      n_vec++;
      if ({hours_bcd, minutes_bcd, seconds_bcd, busy, done, conv_binary} !== 33'd0) begin
        n_err++;
        $display("FAIL reset_hold: out=%h/%h/%h busy=%b done=%b conv=%0d expected all 0",
                 hours_bcd, minutes_bcd, seconds_bcd, busy, done, conv_binary);
      end
    end
    refresh = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({hours_bcd, minutes_bcd, seconds_bcd, busy, conv_binary} !== 32'd0) begin
        n_err++;
        $display("FAIL reset_idle: out=%h/%h/%h busy=%b conv=%0d expected all 0",
                 hours_bcd, minutes_bcd, seconds_bcd, busy, conv_binary);
      end
    end
  endtask

  task automatic test_single();
    logic [6:0] exp_conv[4] = '{7'd12, 7'd34, 7'd56, 7'd0};
    logic       exp_busy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_done[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
    refresh = 1'b1;
    sb_q.push_back(exp_bcd(12, 34, 56));
    for (int e = 0; e < 5; e++) begin
      step();
      refresh = 1'b0;
      n_vec++;
      if (e < 4 && (conv_binary !== exp_conv[e] || busy !== exp_busy[e])) begin
        n_err++;
        $display("FAIL single_E%0d: conv=%0d busy=%b expected conv=%0d busy=%b",
                 e, conv_binary, busy, exp_conv[e], exp_busy[e]);
      end
      if (done !== exp_done[e]) begin
        n_err++;
        $display("FAIL single_done_E%0d: done=%b expected %b", e, done, exp_done[e]);
      end
      if (e < 3 && {hours_bcd, minutes_bcd, seconds_bcd} !== 24'd0) begin
        n_err++;
        $display("FAIL single_early_E%0d: out=%h/%h/%h expected 00/00/00 before commit",
                 e, hours_bcd, minutes_bcd, seconds_bcd);
      end
      if (e == 3 && {hours_bcd, minutes_bcd, seconds_bcd} !== 24'h123456) begin
        n_err++;
        $display("FAIL single_commit: out=%h/%h/%h expected 12/34/56",
                 hours_bcd, minutes_bcd, seconds_bcd);
      end
    end
  endtask

  task automatic test_isolation();
    run_update("iso_prep", 0, 0, 0);
    hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
    refresh = 1'b1;
    sb_q.push_back(exp_bcd(12, 34, 56));
    step();
    refresh = 1'b0;
    hours = 5'd1; minutes = 6'd2; seconds = 6'd3;
    step(); step(); step();
    n_vec++;
    if (done !== 1'b1 || {hours_bcd, minutes_bcd, seconds_bcd} !== 24'h123456) begin
      n_err++;
      $display("FAIL isolation: done=%b out=%h/%h/%h expected done=1 12/34/56",
               done, hours_bcd, minutes_bcd, seconds_bcd);
    end
    step();
    run_update("iso_second", 1, 2, 3);
  endtask

  task automatic test_back_to_back();
    hours = 5'd23; minutes = 6'd59; seconds = 6'd58;
    refresh = 1'b1;
    sb_q.push_back(exp_bcd(23, 59, 58));
    step();                                   // after E0
    seconds = 6'd59;
    sb_q.push_back(exp_bcd(23, 59, 59));
    for (int e = 1; e <= 6; e++) begin
      step();                                 // after E<e>
      refresh = 1'b0;
      n_vec++;
      if (busy !== (e < 6) || done !== (e == 3 || e == 6)) begin
        n_err++;
        $display("FAIL b2b_E%0d: busy=%b done=%b expected busy=%b done=%b",
                 e, busy, done, e < 6, e == 3 || e == 6);
      end
      if (e == 3 && {hours_bcd, minutes_bcd, seconds_bcd} !== 24'h235958) begin
        n_err++;
        $display("FAIL b2b_first: out=%h/%h/%h expected 23/59/58",
                 hours_bcd, minutes_bcd, seconds_bcd);
      end
      if (e == 6 && {hours_bcd, minutes_bcd, seconds_bcd} !== 24'h235959) begin
        n_err++;
        $display("FAIL b2b_second: out=%h/%h/%h expected 23/59/59",
                 hours_bcd, minutes_bcd, seconds_bcd);
      end
    end
    step();
  endtask

  task automatic test_abort();
    run_update("abort_prep", 0, 0, 0);
    hours = 5'd7; minutes = 6'd8; seconds = 6'd9;
    refresh = 1'b1;
    step();                                   // after E0: run started
    refresh = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || conv_binary !== 7'd0 ||
          {hours_bcd, minutes_bcd, seconds_bcd} !== 24'd0) begin
        n_err++;
        $display("FAIL abort_%0d: done=%b busy=%b conv=%0d out=%h/%h/%h expected 0,0,0,00/00/00",
                 i, done, busy, conv_binary, hours_bcd, minutes_bcd, seconds_bcd);
      end
    end
    refresh = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || {hours_bcd, minutes_bcd, seconds_bcd} !== 24'd0) begin
        n_err++;
        $display("FAIL disabled_refresh_%0d: done=%b busy=%b out=%h/%h/%h expected idle 00/00/00",
                 i, done, busy, hours_bcd, minutes_bcd, seconds_bcd);
      end
    end
    refresh = 1'b0;
    en = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reenable: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_extremes();
    run_update("max", 31, 63, 63);
    run_update("zero", 0, 0, 0);
    run_update("mixed", 9, 10, 49);
  endtask

  initial begin
    en = 1'b1; refresh = 1'b0; rst_n = 1'b0;
    hours = '0; minutes = '0; seconds = '0;
    test_reset();
    test_single();
    test_isolation();
    test_back_to_back();
    test_abort();
    test_extremes();
    step(); step();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d commits outstanding, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
